muldiv_unit: RTL and testbench

- Iterative multi-cycle integer multiply/divide unit implementing the RV32M operation set, parametrised in operand width.
- Sits beside the combinational ALU in the execute stage and is the first arithmetic block there with a valid/ready handshake, held results and kill support.
- Multiply uses a radix-2 shift-add datapath and divide uses a radix-2 restoring datapath; both share one WIDTH-bit adder.
- Special divide cases complete without iterating.

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/result handshake bundle for the iterative multiply/divide unit.
// slave: unit side; master: issuing side (execute stage or testbench).
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             i_valid;
   logic             o_ready;
   logic [2:0]       i_opsel;
   logic [WIDTH-1:0] i_op1;
   logic [WIDTH-1:0] i_op2;
   logic             i_kill;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;

   modport slave (
      input  i_valid, i_opsel, i_op1, i_op2,
      input  i_kill, i_ready,
      output o_ready, o_valid, o_result
   );

   modport master (
      output i_valid, i_opsel, i_op1, i_op2,
      output i_kill, i_ready,
      input  o_ready, o_valid, o_result
   );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M iterative mul/div: shift-add multiply, restoring divide, one adder.
// Ports: i_clk, i_rst_n (async low), bus (muldiv_unit_if.slave).
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   muldiv_unit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN =
      {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic [WIDTH-1:0] mc_q, mc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // accept-time decode
   logic             is_div, s1, s2, n1, n2;
   logic             div0, ovf;
   logic [WIDTH-1:0] mag1, mag2, spec_res;

   assign is_div = bus.i_opsel[2];
   assign s2 = (bus.i_opsel == 3'b001)
             | (is_div & ~bus.i_opsel[0]);
   assign s1 = s2 | (bus.i_opsel == 3'b010);
   assign n1 = s1 & bus.i_op1[WIDTH-1];
   assign n2 = s2 & bus.i_op2[WIDTH-1];
   assign mag1 = n1 ? -bus.i_op1 : bus.i_op1;
   assign mag2 = n2 ? -bus.i_op2 : bus.i_op2;
   assign div0 = is_div & (bus.i_op2 == '0);
   assign ovf = is_div & ~bus.i_opsel[0]
              & (bus.i_op1 == MIN)
              & (&bus.i_op2);

   always_comb begin
      spec_res = '0;
      if (div0)
         spec_res = bus.i_opsel[1] ? bus.i_op1 : '1;
      else
         spec_res = bus.i_opsel[1] ? '0 : bus.i_op1;
   end

   // shared adder
   logic [WIDTH-1:0] add_a, add_b, add_sum;
   logic             add_ci, add_co;

   assign {add_co, add_sum} = {1'b0, add_a}
                            + {1'b0, add_b}
                            + {{WIDTH{1'b0}}, add_ci};

   // one iteration; divide tests the shifted
   // remainder, whose top bit sits in acc_q msb
   logic [WIDTH-1:0] acc_it, mq_it;
   logic             ge;

   always_comb begin
      add_a  = acc_q;
      add_b  = mq_q[0] ? mc_q : '0;
      add_ci = 1'b0;
      ge     = 1'b0;
      acc_it = {add_co, add_sum[WIDTH-1:1]};
      mq_it  = {add_sum[0], mq_q[WIDTH-1:1]};
      if (op_q[2]) begin
         add_a  = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
         add_b  = ~mc_q;
         add_ci = 1'b1;
         ge     = acc_q[WIDTH-1] | add_co;
         acc_it = ge ? add_sum : add_a;
         mq_it  = {mq_q[WIDTH-2:0], ge};
      end
   end

   // sign fix-up on the final iteration's values
   logic [2*WIDTH-1:0] prod, prod_f;
   logic [WIDTH-1:0]   q_f, r_f, fix;

   assign prod   = {acc_it, mq_it};
   assign prod_f = neg_q ? -prod : prod;
   assign q_f    = neg_q ? -mq_it : mq_it;
   assign r_f    = neg_q ? -acc_it : acc_it;

   always_comb begin
      fix = '0;
      unique case (1'b1)
         op_q == 3'b000:
            fix = prod_f[WIDTH-1:0];
         ~op_q[2] & (|op_q[1:0]):
            fix = prod_f[2*WIDTH-1:WIDTH];
         op_q[2] & op_q[1]:
            fix = r_f;
         op_q[2] & ~op_q[1]:
            fix = q_f;
         default: fix = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      mc_d    = mc_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               op_d  = bus.i_opsel;
               // remainder follows dividend sign
               neg_d = (is_div & bus.i_opsel[1])
                     ? n1 : (n1 ^ n2);
               acc_d = '0;
               mq_d  = is_div ? mag1 : mag2;
               mc_d  = is_div ? mag2 : mag1;
               cnt_d = '0;
               if (div0 | ovf) begin
                  res_d   = spec_res;
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (bus.i_kill) begin
               state_d = IDLE;
            end else begin
               acc_d = acc_it;
               mq_d  = mq_it;
               cnt_d = cnt_q + CW'(1);
               if (&cnt_q) begin
                  res_d   = fix;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (bus.i_kill | bus.i_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         mq_q    <= '0;
         mc_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         mc_q    <= mc_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.o_ready  = (state_q == IDLE);
   assign bus.o_valid  = (state_q == DONE);
   assign bus.o_result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32.
// Latency is counted in edges after the accept edge.
module tb_muldiv_unit;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   muldiv_unit_if #(.WIDTH(32)) bus ();

   muldiv_unit #(.WIDTH(32)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag,
                         input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int exp_lat,
                         input logic [31:0] exp_res,
                         input logic hold,
                         input logic kill_acc);
      int lat;
      logic [31:0] r0;
      @(negedge clk);
      chk({tag, " ready"}, 32'(bus.o_ready), 1);
      bus.i_valid = 1'b1;
      bus.i_opsel = op;
      bus.i_op1   = a;
      bus.i_op2   = b;
      bus.i_kill  = kill_acc;
      bus.i_ready = ~hold;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      bus.i_kill  = 1'b0;
      bus.i_opsel = ~op;
      bus.i_op1   = ~a;
      bus.i_op2   = ~b;
      lat = 0;
      while (!bus.o_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " result"}, bus.o_result, exp_res);
      if (hold) begin
         r0 = bus.o_result;
         repeat (10) begin
            @(posedge clk); #1;
            chk({tag, " hold valid"},
                32'(bus.o_valid), 1);
            chk({tag, " hold result"},
                bus.o_result, exp_res);
            chk({tag, " hold ready"},
                32'(bus.o_ready), 0);
         end
         chk({tag, " hold stable"}, bus.o_result, r0);
         @(negedge clk);
         bus.i_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk({tag, " valid drop"}, 32'(bus.o_valid), 0);
      chk({tag, " ready back"}, 32'(bus.o_ready), 1);
   endtask

   initial begin
      logic seen;
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_opsel = 3'b000;
      bus.i_op1   = '0;
      bus.i_op2   = '0;
      bus.i_kill  = 1'b0;
      bus.i_ready = 1'b1;
      #12;
      chk("rst ready", 32'(bus.o_ready), 1);
      chk("rst valid", 32'(bus.o_valid), 0);
      chk("rst result", bus.o_result, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD,
             32, 32'hFFFFFFEB, 1'b0, 1'b0);
      run_op("mulh", 3'b001, 32'h80000000,
             32'h80000000, 32, 32'h40000000,
             1'b0, 1'b0);
      run_op("mulhu", 3'b011, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32, 32'hFFFFFFFE,
             1'b0, 1'b0);
      run_op("mulhsu", 3'b010, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32, 32'hFFFFFFFF,
             1'b0, 1'b0);
      run_op("div", 3'b100, 32'hFFFFFFF9, 32'd2,
             32, 32'hFFFFFFFD, 1'b0, 1'b0);
      run_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2,
             32, 32'hFFFFFFFF, 1'b0, 1'b0);
      run_op("divu", 3'b101, 32'd100, 32'd7,
             32, 32'd14, 1'b0, 1'b0);
      run_op("remu", 3'b111, 32'd100, 32'd7,
             32, 32'd2, 1'b0, 1'b0);
      run_op("divu0", 3'b101, 32'd5, 32'd0,
             0, 32'hFFFFFFFF, 1'b0, 1'b0);
      run_op("rem0", 3'b110, 32'd5, 32'd0,
             0, 32'd5, 1'b0, 1'b0);
      run_op("div ovf", 3'b100, 32'h80000000,
             32'hFFFFFFFF, 0, 32'h80000000,
             1'b0, 1'b0);
      run_op("rem ovf", 3'b110, 32'h80000000,
             32'hFFFFFFFF, 0, 32'd0, 1'b0, 1'b0);
      run_op("backpr", 3'b011, 32'h00010000,
             32'h00030000, 32, 32'h00000003,
             1'b1, 1'b0);

      // kill mid-run
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_opsel = 3'b000;
      bus.i_op1   = 32'd3;
      bus.i_op2   = 32'd5;
      bus.i_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("run ready", 32'(bus.o_ready), 0);
      bus.i_kill = 1'b1;
      @(posedge clk); #1;
      bus.i_kill = 1'b0;
      chk("kill valid", 32'(bus.o_valid), 0);
      chk("kill ready", 32'(bus.o_ready), 1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.o_valid) seen = 1'b1;
      end
      chk("kill no result", 32'(seen), 0);
      run_op("post kill", 3'b101, 32'd1000,
             32'd10, 32, 32'd100, 1'b0, 1'b0);
      run_op("kill idle", 3'b000, 32'd6, 32'd7,
             32, 32'd42, 1'b0, 1'b1);

      // async reset mid-run
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_opsel = 3'b101;
      bus.i_op1   = 32'd9;
      bus.i_op2   = 32'd3;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst ready", 32'(bus.o_ready), 1);
      chk("arst valid", 32'(bus.o_valid), 0);
      chk("arst result", bus.o_result, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post rst ready", 32'(bus.o_ready), 1);
      run_op("post rst divu", 3'b101, 32'd9,
             32'd3, 32, 32'd3, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
